// File: rtl/compare_sequencer.sv
// compare_sequencer: initiator side of an external 16-bit comparator.
// Accepts a compare-and-branch request and drives the operands onto the
// comparator. It waits SETTLE_CYC cycles, then samples and decodes the result.
// It returns a branch-taken response together with sticky {lt, gt, eq} flags.
//
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising
// clk edge where valid && ready are both high; valid never depends on ready.
//
// Optional build macro CMP_COUNT_EN adds cmp_count. This output counts the
// responses handshaken with rsp_err=0. It wraps at 16'hFFFF.
module compare_sequencer #(
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_num1,
  input  logic [DATA_W-1:0] req_num2,
  input  logic [2:0]        req_cond,
  output logic [DATA_W-1:0] cmp_num1,
  output logic [DATA_W-1:0] cmp_num2,
  input  logic [DATA_W-1:0] cmp_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_taken,
  output logic [2:0]        flags,
  output logic              rsp_err
`ifdef CMP_COUNT_EN
  ,
  output logic [15:0]       cmp_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Fixed comparator result encodings.
  localparam logic [DATA_W-1:0] LP_RES_EQ = '0;
  localparam logic [DATA_W-1:0] LP_RES_GT = DATA_W'(1);
  localparam logic [DATA_W-1:0] LP_RES_LT = '1;
  localparam logic [3:0]        LP_CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [2:0]        r_cond;
  logic [DATA_W-1:0] r_num1;
  logic [DATA_W-1:0] r_num2;
  logic [2:0]        r_flags;
  logic              r_taken;
  logic              r_err;
  logic              w_accept;
  logic              w_rsp_hs;
  logic              w_legal;
  logic [2:0]        w_new_flags;
  logic              w_cond_true;

  // State register; reset forces IDLE so handshake outputs clear at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decode the comparator result into one-hot {lt, gt, eq} and evaluate the condition.
  always_comb begin
    w_legal     = 1'b1;
    w_new_flags = 3'b000;
    w_cond_true = 1'b0;
    if (cmp_result == LP_RES_EQ)      w_new_flags = 3'b001;
    else if (cmp_result == LP_RES_GT) w_new_flags = 3'b010;
    else if (cmp_result == LP_RES_LT) w_new_flags = 3'b100;
    else                              w_legal     = 1'b0;
    case (r_cond)
      3'b000:  w_cond_true = w_new_flags[0];
      3'b001:  w_cond_true = ~w_new_flags[0];
      3'b010:  w_cond_true = w_new_flags[1];
      3'b011:  w_cond_true = w_new_flags[2];
      3'b100:  w_cond_true = w_new_flags[1] | w_new_flags[0];
      3'b101:  w_cond_true = w_new_flags[2] | w_new_flags[0];
      3'b110:  w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Operand/condition capture, settle countdown, and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num1  <= '0;
      r_num2  <= '0;
      r_cond  <= 3'b000;
      r_cnt   <= 4'd0;
      r_flags <= 3'b000;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num1 <= req_num1;
        r_num2 <= req_num2;
        r_cond <= req_cond;
        r_cnt  <= LP_CNT_LOAD;
      end else if (r_state == ST_SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ST_CAPTURE) begin
        if (w_legal) begin
          r_flags <= w_new_flags;
          r_taken <= w_cond_true;
          r_err   <= 1'b0;
        end else begin
          r_taken <= 1'b0;
          r_err   <= 1'b1;
        end
      end else if (w_rsp_hs) begin
        // The response has been consumed; do not leave stale taken/err behind.
        r_taken <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

`ifdef CMP_COUNT_EN
  logic [15:0] r_count;

  // Count the legal responses the consumer has accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_count <= 16'h0000;
    else if (w_rsp_hs && !r_err) r_count <= r_count + 16'h0001;
  end

  assign cmp_count = r_count;
`endif

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign cmp_num1  = r_num1;
  assign cmp_num2  = r_num2;
  assign rsp_taken = r_taken;
  assign rsp_err   = r_err;
  assign flags     = r_flags;

endmodule

// File: tb/tb_compare_sequencer.sv
// Testbench for compare_sequencer. Instance 0 uses SETTLE_CYC=1 and
// instance 1 uses SETTLE_CYC=4. Each instance is driven by its own
// behavioural comparator. The bench injects illegal comparator results on request.
module tb_compare_sequencer;

  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_taken;
  logic [1:0]  rsp_err;
  logic [15:0] req_num1;
  logic [15:0] req_num2;
  logic [2:0]  req_cond;
  logic [15:0] cmp_num1 [2];
  logic [15:0] cmp_num2 [2];
  logic [15:0] cmp_result [2];
  logic [2:0]  flags [2];
  logic        ill_en;
  logic [15:0] ill_val;
`ifdef CMP_COUNT_EN
  logic [15:0] cmp_count [2];
  logic [15:0] exp_count [2];
`endif

  int checks;
  int errors;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  compare_sequencer #(.DATA_W(16), .SETTLE_CYC(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_num1(req_num1), .req_num2(req_num2), .req_cond(req_cond),
    .cmp_num1(cmp_num1[0]), .cmp_num2(cmp_num2[0]), .cmp_result(cmp_result[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_taken(rsp_taken[0]),
    .flags(flags[0]), .rsp_err(rsp_err[0])
`ifdef CMP_COUNT_EN
    , .cmp_count(cmp_count[0])
`endif
  );

  compare_sequencer #(.DATA_W(16), .SETTLE_CYC(4)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_num1(req_num1), .req_num2(req_num2), .req_cond(req_cond),
    .cmp_num1(cmp_num1[1]), .cmp_num2(cmp_num2[1]), .cmp_result(cmp_result[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_taken(rsp_taken[1]),
    .flags(flags[1]), .rsp_err(rsp_err[1])
`ifdef CMP_COUNT_EN
    , .cmp_count(cmp_count[1])
`endif
  );

  // ---------------- comparator model ----------------
  function automatic logic [15:0] cmp_model(input logic [15:0] a, input logic [15:0] b);
    if (a == b)     return 16'h0000;
    else if (a > b) return 16'h0001;
    else            return 16'hFFFF;
  endfunction

  always_comb cmp_result[0] = ill_en ? ill_val : cmp_model(cmp_num1[0], cmp_num2[0]);
  always_comb cmp_result[1] = ill_en ? ill_val : cmp_model(cmp_num1[1], cmp_num2[1]);

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b);
    return {a < b, a > b, a == b};
  endfunction

  function automatic logic ref_taken(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return a > b;
      3'd3:    return a < b;
      3'd4:    return a >= b;
      3'd5:    return a <= b;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int settle_of(input int s);
    return (s == 0) ? 1 : 4;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input int s, input string tag);
    check({tag, " req_ready"}, 32'(req_ready[s]), 32'd1);
    check({tag, " rsp_valid"}, 32'(rsp_valid[s]), 32'd0);
    check({tag, " rsp_taken"}, 32'(rsp_taken[s]), 32'd0);
    check({tag, " rsp_err"},   32'(rsp_err[s]),   32'd0);
    check({tag, " flags"},     32'(flags[s]),     32'd0);
    check({tag, " cmp_num1"},  32'(cmp_num1[s]),  32'd0);
    check({tag, " cmp_num2"},  32'(cmp_num2[s]),  32'd0);
`ifdef CMP_COUNT_EN
    check({tag, " cmp_count"}, 32'(cmp_count[s]), 32'd0);
`endif
  endtask

  // ---------------- driver ----------------
  // Entered and left at a falling edge.
  task automatic do_txn(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] c, input logic ill, input logic [15:0] iv,
                        input int dly, input logic e_taken, input logic [2:0] e_flags,
                        input logic e_err, input string tag);
    int n;
    n = 0;
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready before accept"}, 32'(req_ready[s]), 32'd1);
    ill_en   = ill;
    ill_val  = iv;
    req_num1 = a;
    req_num2 = b;
    req_cond = c;
    rsp_ready[s] = 1'b0;
    req_valid[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_num1 = 16'($urandom);
    req_num2 = 16'($urandom);
    req_cond = 3'($urandom_range(0, 7));
    check({tag, " cmp_num1 latched"}, 32'(cmp_num1[s]), 32'(a));
    check({tag, " cmp_num2 latched"}, 32'(cmp_num2[s]), 32'(b));
    n = 0;
    while (!rsp_valid[s] && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(settle_of(s) + 1));
    check({tag, " rsp_taken"}, 32'(rsp_taken[s]), 32'(e_taken));
    check({tag, " rsp_err"},   32'(rsp_err[s]),   32'(e_err));
    check({tag, " flags"},     32'(flags[s]),     32'(e_flags));
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      check({tag, " hold rsp_valid"}, 32'(rsp_valid[s]), 32'd1);
      check({tag, " hold rsp_taken"}, 32'(rsp_taken[s]), 32'(e_taken));
      check({tag, " hold rsp_err"},   32'(rsp_err[s]),   32'(e_err));
      check({tag, " hold req_ready"}, 32'(req_ready[s]), 32'd0);
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    ill_en = 1'b0;
    check({tag, " rsp_valid after hs"}, 32'(rsp_valid[s]), 32'd0);
    check({tag, " req_ready after hs"}, 32'(req_ready[s]), 32'd1);
    check({tag, " cmp_num1 retained"}, 32'(cmp_num1[s]), 32'(a));
    check({tag, " flags after hs"}, 32'(flags[s]), 32'(e_flags));
`ifdef CMP_COUNT_EN
    if (!e_err) exp_count[s] = exp_count[s] + 16'h0001;
    check({tag, " cmp_count"}, 32'(cmp_count[s]), 32'(exp_count[s]));
`endif
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  c;
    logic        ill;
    logic [15:0] iv;
    int          dly;
    logic        taken;
    logic [2:0]  fl;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [2:0]  mflags;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] iv;
    logic [2:0]  c;
    logic        ill;
    logic        e_taken;
    logic [2:0]  e_flags;
    int          n;
    int          seen;

    checks    = 0;
    errors    = 0;
    rst_n     = 2'b00;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_num1  = 16'h0000;
    req_num2  = 16'h0000;
    req_cond  = 3'b000;
    ill_en    = 1'b0;
    ill_val   = 16'h0000;
`ifdef CMP_COUNT_EN
    exp_count[0] = 16'h0000;
    exp_count[1] = 16'h0000;
`endif

    //           a         b         cond  ill   iv        dly taken fl      err
    vecs[0]  = '{16'h0001, 16'h0001, 3'd0, 1'b0, 16'h0000, 0, 1'b1, 3'b001, 1'b0};
    vecs[1]  = '{16'h0004, 16'h0001, 3'd2, 1'b0, 16'h0000, 0, 1'b1, 3'b010, 1'b0};
    vecs[2]  = '{16'h0004, 16'h0001, 3'd5, 1'b0, 16'h0000, 0, 1'b0, 3'b010, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0004, 3'd3, 1'b0, 16'h0000, 5, 1'b1, 3'b100, 1'b0};
    vecs[4]  = '{16'h0004, 16'h0001, 3'd2, 1'b0, 16'h0000, 0, 1'b1, 3'b010, 1'b0};
    vecs[5]  = '{16'h0009, 16'h0003, 3'd4, 1'b1, 16'h0002, 2, 1'b0, 3'b010, 1'b1};
    vecs[6]  = '{16'h0000, 16'hFFFF, 3'd1, 1'b0, 16'h0000, 1, 1'b1, 3'b100, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'h0000, 3'd6, 1'b0, 16'h0000, 0, 1'b1, 3'b010, 1'b0};
    vecs[8]  = '{16'h0005, 16'h0005, 3'd7, 1'b0, 16'h0000, 0, 1'b0, 3'b001, 1'b0};
    vecs[9]  = '{16'h0005, 16'h0005, 3'd4, 1'b0, 16'h0000, 0, 1'b1, 3'b001, 1'b0};
    vecs[10] = '{16'h0003, 16'h0005, 3'd5, 1'b0, 16'h0000, 0, 1'b1, 3'b100, 1'b0};
    vecs[11] = '{16'h0003, 16'h0005, 3'd6, 1'b1, 16'h8000, 0, 1'b0, 3'b100, 1'b1};

    // ---- reset ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals(0, "reset0");
    check_reset_vals(1, "reset1");
    rst_n = 2'b11;
    @(negedge clk);

    // ---- table-driven vectors on SETTLE_CYC=1 ----
    for (int i = 0; i < 12; i++) begin
      do_txn(0, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ill, vecs[i].iv, vecs[i].dly,
             vecs[i].taken, vecs[i].fl, vecs[i].err, $sformatf("vec%0d", i));
    end
    mflags = vecs[11].fl;

    // ---- randomized transactions against the reference model ----
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 16'h0001;
        default: b = 16'($urandom);
      endcase
      c   = 3'($urandom_range(0, 7));
      ill = ($urandom_range(0, 7) == 0);
      iv  = 16'($urandom);
      while (iv == 16'h0000 || iv == 16'h0001 || iv == 16'hFFFF) iv = 16'($urandom);
      if (ill) begin
        e_taken = 1'b0;
        e_flags = mflags;
      end else begin
        e_taken = ref_taken(c, a, b);
        e_flags = ref_flags(a, b);
      end
      do_txn(0, a, b, c, ill, iv, $urandom_range(0, 3), e_taken, e_flags, ill,
             $sformatf("rnd%0d", i));
      mflags = e_flags;
    end

    // ---- SETTLE_CYC=4: normal transaction ----
    do_txn(1, 16'h0002, 16'h0009, 3'd3, 1'b0, 16'h0000, 1, 1'b1, 3'b100, 1'b0, "s4 first");

    // ---- SETTLE_CYC=4: abort by reset during SETTLE ----
    req_num1 = 16'h0007;
    req_num2 = 16'h0002;
    req_cond = 3'd2;
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // A request presented while busy must be ignored and must not disturb the operands.
    req_num1 = 16'h1234;
    req_num2 = 16'h5678;
    @(negedge clk);
    check("s4 busy req_ready", 32'(req_ready[1]), 32'd0);
    check("s4 busy cmp_num1 held", 32'(cmp_num1[1]), 32'h0007);
    check("s4 busy cmp_num2 held", 32'(cmp_num2[1]), 32'h0002);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check_reset_vals(1, "s4 midreset");
`ifdef CMP_COUNT_EN
    exp_count[1] = 16'h0000;
`endif
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 0;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid[1]) seen++;
    end
    check("s4 no response after abort", 32'(seen), 32'd0);
    check("s4 flags cleared", 32'(flags[1]), 32'd0);
    do_txn(1, 16'hABCD, 16'hABCD, 3'd0, 1'b0, 16'h0000, 0, 1'b1, 3'b001, 1'b0, "s4 after reset");

    // ---- back-to-back spacing with rsp_ready held high (SETTLE_CYC=1) ----
    rsp_ready[0] = 1'b1;
    req_num1 = 16'h0010;
    req_num2 = 16'h0020;
    req_cond = 3'd3;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    while (!(req_ready[0] && req_valid[0]) && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("b2b spacing", 32'(n), 32'd4);
    check("b2b flags", 32'(flags[0]), 32'b100);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
